ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 8, RAM address width.
REQ-002 SHALL have parameter DATA_W, 16, RAM data width.
REQ-003 SHALL have parameter RD_LAT, 1, RAM read latency in cycles from the enable-sampling edge (legal 1..2).
REQ-004 SHALL have port i_sys_clk  in  1  clock; all logic is single-clock, rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have ports i_req0_valid / i_req1_valid  in  1  access request, one per requester.
REQ-007 SHALL have ports i_req0_we / i_req1_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports i_req0_addr / i_req1_addr  in  ADDR_W  access address.
REQ-009 SHALL have ports i_req0_wdata / i_req1_wdata  in  DATA_W  write data.
REQ-010 SHALL have ports o_req0_ready / o_req1_ready  out  1  grant; the request is accepted when valid & ready at a rising edge.
REQ-011 SHALL have ports o_req0_rvalid / o_req1_rvalid  out  1  one-cycle read-data strobe.
REQ-012 SHALL have ports o_req0_rdata / o_req1_rdata  out  DATA_W  read data, meaningful only while rvalid is high.
REQ-013 SHALL have ports o_ram_en, o_ram_we  out  1 each  single-port RAM enable and write enable.
REQ-014 SHALL have ports o_ram_addr  out  ADDR_W  and  o_ram_din  out  DATA_W  RAM address and write data.
REQ-015 SHALL have port i_ram_dout  in  DATA_W  RAM read data.
REQ-016 SHALL have port o_init_done  out  1  high once RAM clear is complete.

Function
REQ-017 SHALL implement FSM states INIT and ARB; reset enters INIT.
REQ-018 INIT SHALL write zero to addresses 0..2^ADDR_W-1, one per cycle, via a clear counter; both readies low.
REQ-019 After the write to the last address is issued, the FSM SHALL go to ARB, and o_init_done SHALL rise the next cycle and stay high until reset.
REQ-020 In ARB, ready SHALL be combinational from the valids and the priority pointer: a lone valid is granted the same cycle; at most one ready is high per cycle.
REQ-021 When both are valid, the grant SHALL go to the requester not granted last (round-robin); the pointer updates only on an accepted grant; after reset the pointer favours req0.
REQ-022 o_ram_en/we/addr/din SHALL be registered: an acceptance at edge k drives them after edge k; with no acceptance, o_ram_en and o_ram_we are 0.
REQ-023 Each accepted read SHALL push a requester tag through a (1+RD_LAT)-deep valid/tag shift pipe.
REQ-024 The pipe output SHALL register i_ram_dout into the tagged requester's rdata and pulse its rvalid; total latency from acceptance edge to rvalid high is RD_LAT+2 cycles.
REQ-025 Back-to-back reads SHALL sustain one per cycle with in-order data; writes produce no rvalid.
REQ-026 A read of an address written in the immediately preceding accepted cycle SHALL return the new data (RAM configured write-first or read-first irrelevant: accesses are serialized).
REQ-027 Address and data SHALL pass unmodified; no wrap logic beyond ADDR_W truncation of the clear counter.

Reset
REQ-028 On i_rst_n low, asynchronously: FSM = INIT, clear counter = 0, pointer = req0, pipe valids = 0, all outputs 0 (ready, rvalid, rdata, ram_en, ram_we, ram_addr, ram_din, init_done).
REQ-029 Reset mid-operation SHALL drop in-flight reads without rvalid and restart the clear from address 0.

Structure
REQ-030 Package ram_arb_pkg SHALL hold the ADDR_W/DATA_W defaults and the FSM state encodings.
REQ-031 Round-robin grant logic SHALL be sub-module rr_arb2 (2 valids + pointer in, one-hot grant out).

Verification
REQ-032 Reset release -> o_ram_en/we high for exactly 256 cycles at addresses 0..255 with din 0; o_init_done rises 1 cycle after the last write; readies low throughout.
REQ-033 req0 writes 0x00AB to 0x10, then reads 0x10 -> o_req0_rvalid with rdata 0x00AB exactly RD_LAT+2 cycles after the read acceptance.
REQ-034 Both valid continuously for 8 cycles -> grants alternate 0,1,0,1...; each requester gets 4 grants.
REQ-035 req1 issues 4 back-to-back reads of 0x20..0x23 after writes 1..4 -> 4 consecutive rvalid cycles carrying 1,2,3,4; o_req0_rvalid stays 0.
REQ-036 Assert reset with 2 reads in flight -> no rvalid fires; clear restarts at address 0.
REQ-037 Read of an unwritten address after init -> rdata 0x0000.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths and FSM state encodings for the RAM port arbiter.
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int ST_W = 1;
  localparam logic [ST_W-1:0] ST_INIT = 1'b0;
  localparam logic [ST_W-1:0] ST_ARB  = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; ptr_i high favours requester 1 on contention.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[0] = valid_i[0] & (~valid_i[1] | ~ptr_i);
  assign gnt_o[1] = valid_i[1] & (~valid_i[0] | ptr_i);
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: clears a single-port RAM after reset, then arbitrates two requesters onto it.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic              i_req1_valid,
  input  logic              i_req0_we,
  input  logic              i_req1_we,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req0_wdata,
  input  logic [DATA_W-1:0] i_req1_wdata,
  output logic              o_req0_ready,
  output logic              o_req1_ready,
  output logic              o_req0_rvalid,
  output logic              o_req1_rvalid,
  output logic [DATA_W-1:0] o_req0_rdata,
  output logic [DATA_W-1:0] o_req1_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_init_done
);
  logic [ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              ptr_q, ptr_d;
  logic              in_arb, acc, acc_we, rd_acc;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_din;
  logic [RD_LAT:0]   pv_q, pt_q;
  logic              out_v, out_t;
  logic              ram_en_q, ram_we_q, init_done_q, rv0_q, rv1_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q, rd0_q, rd1_q;

  assign in_arb = state_q == ST_ARB;

  rr_arb2 u_rr_arb2 (
    .valid_i({i_req1_valid, i_req0_valid} & {2{in_arb}}),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt)
  );

  assign acc      = |gnt;
  assign acc_we   = gnt[1] ? i_req1_we : i_req0_we;
  assign acc_addr = gnt[1] ? i_req1_addr : i_req0_addr;
  assign acc_din  = gnt[1] ? i_req1_wdata : i_req0_wdata;
  assign rd_acc   = acc & ~acc_we;
  assign out_v    = pv_q[RD_LAT];
  assign out_t    = pt_q[RD_LAT];

  always_comb begin
    state_d = (!in_arb && &clr_q) ? ST_ARB : state_q;
    clr_d   = in_arb ? clr_q : clr_q + 1'b1;
    ptr_d   = acc ? gnt[0] : ptr_q;
  end

  // Tag pipe tracks which requester owns each read still travelling through the RAM.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_INIT;
      clr_q       <= '0;
      ptr_q       <= 1'b0;
      pv_q        <= '0;
      pt_q        <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      init_done_q <= 1'b0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
      rd0_q       <= '0;
      rd1_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      ptr_q       <= ptr_d;
      pv_q        <= {pv_q[RD_LAT-1:0], rd_acc};
      pt_q        <= {pt_q[RD_LAT-1:0], gnt[1]};
      ram_en_q    <= !in_arb || acc;
      ram_we_q    <= !in_arb || (acc && acc_we);
      ram_addr_q  <= in_arb ? acc_addr : clr_q;
      ram_din_q   <= in_arb ? acc_din : '0;
      init_done_q <= in_arb;
      rv0_q       <= out_v & ~out_t;
      rv1_q       <= out_v & out_t;
      rd0_q       <= (out_v & ~out_t) ? i_ram_dout : rd0_q;
      rd1_q       <= (out_v & out_t) ? i_ram_dout : rd1_q;
    end
  end

  assign o_req0_ready  = gnt[0];
  assign o_req1_ready  = gnt[1];
  assign o_req0_rvalid = rv0_q;
  assign o_req1_rvalid = rv1_q;
  assign o_req0_rdata  = rd0_q;
  assign o_req1_rdata  = rd1_q;
  assign o_ram_en      = ram_en_q;
  assign o_ram_we      = ram_we_q;
  assign o_ram_addr    = ram_addr_q;
  assign o_ram_din     = ram_din_q;
  assign o_init_done   = init_done_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed self-checking bench with a behavioural single-port RAM.
module tb_ram_port_arbiter;
  localparam int RD_LAT = 1;
  logic clk = 1'b0;
  logic rst_n;
  logic v0, v1, we0, we1;
  logic [7:0] a0, a1;
  logic [15:0] d0, d1;
  logic r0, r1, rv0, rv1;
  logic [15:0] rd0, rd1;
  logic ram_en, ram_we, done;
  logic [7:0] ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic [15:0] mem [256];
  logic [15:0] dq [RD_LAT];
  int n_cmp = 0;
  int n_err = 0;
  int g0, g1;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .i_req1_valid(v1), .i_req0_we(we0), .i_req1_we(we1),
    .i_req0_addr(a0), .i_req1_addr(a1), .i_req0_wdata(d0), .i_req1_wdata(d1),
    .o_req0_ready(r0), .o_req1_ready(r1), .o_req0_rvalid(rv0), .o_req1_rvalid(rv1),
    .o_req0_rdata(rd0), .o_req1_rdata(rd1), .o_ram_en(ram_en), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_din(ram_din), .i_ram_dout(ram_dout), .o_init_done(done)
  );

  // Synchronous RAM: dout reflects the enable-sampling edge's read RD_LAT-1 edges later.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      dq[0] <= mem[ram_addr];
    end
    for (int i = 1; i < RD_LAT; i++) dq[i] <= dq[i-1];
  end
  assign ram_dout = dq[RD_LAT-1];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [7:0] a, input logic [15:0] d);
    if (p == 0) begin v0 = v; we0 = we; a0 = a; d0 = d; end
    else begin v1 = v; we1 = we; a1 = a; d1 = d; end
  endtask

  task automatic single_write(input int p, input logic [7:0] a, input logic [15:0] d);
    drive(p, 1'b1, 1'b1, a, d);
    #1 chk("wr_rdy", p == 0 ? r0 : r1, 1);
    @(negedge clk);
    drive(p, 1'b0, 1'b0, 8'h0, 16'h0);
    chk("wr_ram", {ram_en, ram_we, ram_addr, ram_din}, {2'b11, a, d});
  endtask

  task automatic single_read(input int p, input logic [7:0] a, input logic [15:0] e);
    drive(p, 1'b1, 1'b0, a, 16'h0);
    #1 chk("rd_rdy", p == 0 ? r0 : r1, 1);
    for (int n = 1; n <= RD_LAT + 3; n++) begin
      @(negedge clk);
      if (n == 1) begin
        drive(p, 1'b0, 1'b0, 8'h0, 16'h0);
        chk("rd_ram", {ram_en, ram_we, ram_addr}, {2'b10, a});
      end
      chk("rd_rvalid", p == 0 ? rv0 : rv1, n == RD_LAT + 2);
      chk("rd_other", p == 0 ? rv1 : rv0, 0);
      if (n == RD_LAT + 2) chk("rd_data", p == 0 ? rd0 : rd1, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h05, 16'h0);
    drive(1, 1'b1, 1'b0, 8'h06, 16'h0);
    repeat (2) @(negedge clk);
    chk("rst_out", {r0, r1, rv0, rv1, rd0, rd1, ram_en, ram_we, ram_addr, ram_din, done}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk("init", {ram_en, ram_we, ram_addr, ram_din, r0, r1, done}, {2'b11, i[7:0], 16'h0, 3'b000});
      if (i == 254) begin
        drive(0, 1'b0, 1'b0, 8'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 8'h0, 16'h0);
      end
    end
    @(negedge clk);
    chk("init_end", {ram_en, ram_we, done}, 3'b001);

    single_write(0, 8'h10, 16'h00AB);
    single_read(0, 8'h10, 16'h00AB);
    single_read(1, 8'h80, 16'h0000);

    drive(0, 1'b1, 1'b1, 8'h40, 16'h1111);
    drive(1, 1'b1, 1'b1, 8'h41, 16'h2222);
    g0 = 0;
    g1 = 0;
    for (int c = 0; c < 8; c++) begin
      #1 chk("rr_gnt", {r1, r0}, c % 2 == 0 ? 2'b01 : 2'b10);
      g0 += int'(r0);
      g1 += int'(r1);
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 8'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 16'h0);
    chk("rr_cnt0", g0, 4);
    chk("rr_cnt1", g1, 4);

    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 1'b1, 8'(32 + i), 16'(i + 1));
      #1 chk("b2b_wr_rdy", r1, 1);
      @(negedge clk);
    end
    for (int c = 0; c < RD_LAT + 8; c++) begin
      int j;
      j = c - RD_LAT - 2;
      chk("b2b_rv1", rv1, j >= 0 && j < 4);
      if (j >= 0 && j < 4) chk("b2b_data", rd1, j + 1);
      chk("b2b_rv0", rv0, 0);
      if (c < 4) begin
        drive(1, 1'b1, 1'b0, 8'(32 + c), 16'h0);
        #1 chk("b2b_rd_rdy", r1, 1);
      end else drive(1, 1'b0, 1'b0, 8'h0, 16'h0);
      @(negedge clk);
    end

    drive(0, 1'b1, 1'b0, 8'h10, 16'h0);
    #1 chk("fly_rdy0", r0, 1);
    @(negedge clk);
    #1 chk("fly_rdy1", r0, 1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 8'h0, 16'h0);
    rst_n = 1'b0;
    #1 chk("rst_mid", {rv0, rv1, ram_en, done}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", {rv0, rv1, ram_en}, 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("reclear", {ram_en, ram_we, ram_addr, rv0, rv1, done}, {2'b11, 8'(c), 3'b000});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
